// File: rtl/bus_cmd_arbiter.sv
// Round-robin command arbiter/sequencer sharing one tagged request/response bus.
// Optional WAIT timeout with ERROR completion is enabled by defining BUS_CMD_ARB_TIMEOUT_EN.
module bus_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*3-1:0]      req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic [2:0]                bus_cmd,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic [ID_W-1:0]           bus_id,
  input  logic                      bus_rsp_valid,
  input  logic [ID_W-1:0]           bus_rsp_id,
  input  logic [DATA_W-1:0]         bus_rsp_data,
  output logic [1:0]                state,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [2:0]          bus_cmd_q, bus_cmd_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [ID_W-1:0]     bus_id_q, bus_id_d;
  logic                bus_req_valid_q;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                busy_q;

  logic                found_s;
  logic [PTR_W-1:0]    win_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic                rsp_match_s;

  logic [2:0]          cmd_arr_s   [NUM_REQ];
  logic [ADDR_W-1:0]   addr_arr_s  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr_s [NUM_REQ];

`ifdef BUS_CMD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_arr_s[g]   = req_cmd[3*g +: 3];
    assign addr_arr_s[g]  = req_addr[ADDR_W*g +: ADDR_W];
    assign wdata_arr_s[g] = req_wdata[DATA_W*g +: DATA_W];
  end

  // Round-robin search starting at ptr_q, wrapping past the top requester.
  always_comb begin
    int idx_v;
    found_s = 1'b0;
    win_s   = '0;
    idx_v   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v = (int'(ptr_q) + i) % NUM_REQ;
      if (!found_s && req_valid[PTR_W'(idx_v)]) begin
        found_s = 1'b1;
        win_s   = PTR_W'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot accept, offered only while idle.
  always_comb begin
    grant_s = '0;
    if (state_q == ST_IDLE) begin
      grant_s[win_s] = found_s;
    end else begin
      grant_s = '0;
    end
  end

  assign rsp_match_s = bus_rsp_valid && (bus_rsp_id == bus_id_q);

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    id_d        = id_q;
    bus_cmd_d   = bus_cmd_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_id_d    = bus_id_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
`ifdef BUS_CMD_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          bus_cmd_d   = cmd_arr_s[win_s];
          bus_addr_d  = addr_arr_s[win_s];
          bus_wdata_d = wdata_arr_s[win_s];
          bus_id_d    = id_q;
          id_d        = id_q + ID_W'(1);
          owner_d     = win_s;
          ptr_d       = (win_s == PTR_W'(NUM_REQ - 1)) ? '0 : win_s + PTR_W'(1);
          state_d     = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (bus_req_valid_q && bus_req_ready) begin
          state_d = ST_WAIT;
`ifdef BUS_CMD_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_WAIT: begin
        if (rsp_match_s) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = bus_rsp_data;
          state_d              = ST_IDLE;
`ifdef BUS_CMD_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // A response in the final counted cycle is taken above, so it beats the timeout.
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_ERROR: begin
`ifdef BUS_CMD_ARB_TIMEOUT_EN
        rsp_valid_d[owner_q] = 1'b1;
        rsp_err_d            = 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      owner_q         <= '0;
      id_q            <= '0;
      bus_cmd_q       <= 3'b000;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_id_q        <= '0;
      bus_req_valid_q <= 1'b0;
      rsp_valid_q     <= '0;
      rsp_rdata_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      owner_q         <= owner_d;
      id_q            <= id_d;
      bus_cmd_q       <= bus_cmd_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_id_q        <= bus_id_d;
      bus_req_valid_q <= (state_d == ST_ACTIVE);
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      busy_q          <= (state_d != ST_IDLE);
    end
  end

`ifdef BUS_CMD_ARB_TIMEOUT_EN
  // WAIT-cycle counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready     = grant_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_cmd       = bus_cmd_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_id        = bus_id_q;
  assign state         = state_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_bus_cmd_arbiter.sv
// Directed self-checking bench for bus_cmd_arbiter (4 requesters, default widths).
// Timeout checks compile in when BUS_CMD_ARB_TIMEOUT_EN is defined.
module tb_bus_cmd_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [11:0]  req_cmd;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         bus_req_valid;
  logic         bus_req_ready;
  logic [2:0]   bus_cmd;
  logic [7:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_id;
  logic         bus_rsp_valid;
  logic [3:0]   bus_rsp_id;
  logic [31:0]  bus_rsp_data;
  logic [1:0]   state;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester fields: 0 READ, 1 ERASE, 2 WRITE, 3 FLUSH.
  logic [2:0]  exp_cmd   [4] = '{3'b000, 3'b010, 3'b001, 3'b011};
  logic [7:0]  exp_addr  [4] = '{8'h0A, 8'h1B, 8'h3C, 8'h4D};
  logic [31:0] exp_wdata [4] = '{32'h1111_0000, 32'h2222_1111, 32'hDEAD_BEEF, 32'h4444_3333};

  bus_cmd_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .DATA_W(32), .ID_W(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_id(bus_id),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_id(bus_rsp_id), .bus_rsp_data(bus_rsp_data),
    .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Full transaction: grant, optional backpressure, accept, optional stray response, response.
  task automatic txn(input logic [3:0] vmask, input logic [1:0] win, input logic [3:0] eid,
                     input int stall, input bit stray, input logic [31:0] rdata);
    logic [3:0] oh;
    oh = 4'b0001 << win;
    req_valid = vmask;
    #1;
    check_eq("grant", req_ready, oh);
    step();
    req_valid = 4'b0000;
    check_eq("active_state", state, 2'b01);
    check_eq("bus_req_valid", bus_req_valid, 1'b1);
    check_eq("bus_cmd", bus_cmd, exp_cmd[win]);
    check_eq("bus_addr", bus_addr, exp_addr[win]);
    check_eq("bus_wdata", bus_wdata, exp_wdata[win]);
    check_eq("bus_id", bus_id, eid);
    check_eq("no_grant_busy", req_ready, 4'b0000);
    if (stall > 0) begin
      repeat (stall) step();
      check_eq("stall_state", state, 2'b01);
      check_eq("stall_valid", bus_req_valid, 1'b1);
      check_eq("stall_addr", bus_addr, exp_addr[win]);
      check_eq("stall_wdata", bus_wdata, exp_wdata[win]);
    end
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    check_eq("wait_state", state, 2'b10);
    check_eq("valid_dropped", bus_req_valid, 1'b0);
    if (stray) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_id    = eid ^ 4'h5;
      bus_rsp_data  = 32'h0000_0BAD;
      step();
      bus_rsp_valid = 1'b0;
      check_eq("stray_state", state, 2'b10);
      check_eq("stray_rsp", rsp_valid, 4'b0000);
    end
    bus_rsp_valid = 1'b1;
    bus_rsp_id    = eid;
    bus_rsp_data  = rdata;
    step();
    bus_rsp_valid = 1'b0;
    check_eq("rsp_valid", rsp_valid, oh);
    check_eq("rsp_rdata", rsp_rdata, rdata);
    check_eq("rsp_err", rsp_err, 1'b0);
    check_eq("idle_state", state, 2'b00);
    step();
    check_eq("rsp_pulse_end", rsp_valid, 4'b0000);
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 4'b0000;
    req_cmd       = {3'b011, 3'b001, 3'b010, 3'b000};
    req_addr      = {8'h4D, 8'h3C, 8'h1B, 8'h0A};
    req_wdata     = {32'h4444_3333, 32'hDEAD_BEEF, 32'h2222_1111, 32'h1111_0000};
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_id    = 4'h0;
    bus_rsp_data  = 32'h0;
    step();
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_bus_valid", bus_req_valid, 1'b0);
    check_eq("rst_bus_id", bus_id, 4'h0);
    check_eq("rst_bus_addr", bus_addr, 8'h00);
    check_eq("rst_rsp_valid", rsp_valid, 4'b0000);
    check_eq("rst_req_ready", req_ready, 4'b0000);
    rst_n = 1'b1;
    step();

    // Single WRITE from requester 2; afterwards the pointer sits at 3.
    txn(4'b0100, 2'd2, 4'h0, 0, 1'b0, 32'h0000_1234);
    req_valid = 4'b1111;
    #1;
    check_eq("ptr_after_single", req_ready, 4'b1000);
    req_valid = 4'b0000;
    #1;
    check_eq("no_req_no_grant", req_ready, 4'b0000);
    do_reset();

    // Round-robin with all requesters asserting.
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, 2'(k % 4), 4'(k), 0, 1'b0, 32'hC0DE_0000 + 32'(k));
    end

    // Backpressure then a mismatched id before the real response.
    txn(4'b1010, 2'd1, 4'h5, 5, 1'b1, 32'h5555_AAAA);

    // Id wrap over 17 back-to-back transactions.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      txn(4'b1111, 2'(k % 4), 4'(k % 16), 0, 1'b0, 32'hA000_0000 + 32'(k));
    end

`ifdef BUS_CMD_ARB_TIMEOUT_EN
    // No response: ERROR after the 16th WAIT cycle, then an error pulse.
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    check_eq("to_bus_id", bus_id, 4'h1);
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    repeat (15) step();
    check_eq("to_still_wait", state, 2'b10);
    step();
    check_eq("to_error", state, 2'b11);
    check_eq("to_error_norsp", rsp_valid, 4'b0000);
    step();
    check_eq("to_rsp_valid", rsp_valid, 4'b0100);
    check_eq("to_rsp_err", rsp_err, 1'b1);
    check_eq("to_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("to_idle", state, 2'b00);
    step();
    // Response in the 16th WAIT cycle completes normally.
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    repeat (15) step();
    bus_rsp_valid = 1'b1;
    bus_rsp_id    = 4'h2;
    bus_rsp_data  = 32'h0000_0016;
    step();
    bus_rsp_valid = 1'b0;
    check_eq("late_rsp_valid", rsp_valid, 4'b0100);
    check_eq("late_rsp_err", rsp_err, 1'b0);
    check_eq("late_rsp_rdata", rsp_rdata, 32'h0000_0016);
    step();
`endif

    // Reset while waiting for a response.
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    check_eq("pre_rst_wait", state, 2'b10);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", state, 2'b00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_bus_valid", bus_req_valid, 1'b0);
    check_eq("mid_rst_bus_addr", bus_addr, 8'h00);
    check_eq("mid_rst_bus_wdata", bus_wdata, 32'h0);
    check_eq("mid_rst_bus_id", bus_id, 4'h0);
    step();
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_id    = 4'h0;
    step();
    bus_rsp_valid = 1'b0;
    check_eq("post_rst_norsp", rsp_valid, 4'b0000);
    check_eq("post_rst_idle", state, 2'b00);
    txn(4'b1111, 2'd0, 4'h0, 0, 1'b0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
